// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI command arbiter.
package spi_arb_pkg;

    localparam int unsigned CMD_W     = 10;
    localparam int unsigned RD_W      = 8;
    localparam logic [1:0]  RD_OPCODE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
module spi_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    always_comb begin
        int unsigned k;
        k     = 0;
        grant = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            k = (32'(last_grant) + i) % NUM_REQ;
            if (!valid && req[IDX_W'(k)]) begin
                valid = 1'b1;
                grant = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin arbitration.
// Define SPI_ARB_TIMEOUT_EN to abort WAIT_DONE after TIMEOUT_CYC cycles (err=1, rdata=8'hFF).
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] cmd,
    output logic [NUM_REQ-1:0]       ack,
    output logic [RD_W-1:0]          rdata,
    output logic                     err,
    output logic                     m_start,
    output logic [CMD_W-1:0]         m_data_in,
    input  logic [RD_W-1:0]          m_data_out,
    input  logic                     m_busy,
    input  logic                     m_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_cmd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    logic [CMD_W-1:0] cmd_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
        assign cmd_arr[g] = cmd[CMD_W*g +: CMD_W];
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               m_start_q, m_start_d;
    logic [CMD_W-1:0]   m_data_in_q, m_data_in_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [RD_W-1:0]    rdata_q, rdata_d;
    logic [IDX_W-1:0]   rr_grant;
    logic               rr_valid;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .valid      (rr_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_start_d    = 1'b0;
        m_data_in_d  = m_data_in_q;
        ack_d        = '0;
        rdata_d      = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Hold off while the master still reports busy.
                if (rr_valid && !m_busy) begin
                    grant_d     = rr_grant;
                    m_data_in_d = cmd_arr[rr_grant];
                    m_start_d   = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT_DONE: begin
                if (m_done) begin
                    state_d        = RESP;
                    ack_d[grant_q] = 1'b1;
                    rdata_d = (m_data_in_q[CMD_W-1 -: 2] == RD_OPCODE) ? m_data_out : '0;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d        = RESP;
                    ack_d[grant_q] = 1'b1;
                    rdata_d        = '1;
                    err_d          = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            m_start_q    <= 1'b0;
            m_data_in_q  <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_start_q    <= m_start_d;
            m_data_in_q  <= m_data_in_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign m_start   = m_start_q;
    assign m_data_in = m_data_in_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one SPI master (legal 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 64, meaning WAIT_DONE cycles before abort (used only with SPI_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  in  NUM_REQ  per-requester request, level, held until ack.
REQ-006 The block SHALL have port cmd  in  NUM_REQ*10  flattened 10-bit commands, requester i at [10*i+9:10*i].
REQ-007 The block SHALL have port ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-008 The block SHALL have port rdata  out  8  read result, valid only while ack is nonzero.
REQ-009 The block SHALL have port err  out  1  timeout flag, valid only while ack is nonzero.
REQ-010 The block SHALL have port m_start  out  1  start to the SPI master.
REQ-011 The block SHALL have port m_data_in  out  10  command to the SPI master.
REQ-012 The block SHALL have ports m_data_out  in  8, m_busy  in  1, m_done  in  1, all from the SPI master.

Function
REQ-013 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE, RESP.
REQ-014 IDLE: if any req bit is high, the block SHALL pick the winner round-robin, latch its index and cmd into m_data_in and go to LAUNCH; else it stays in IDLE.
REQ-015 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ; after reset last_grant = NUM_REQ-1, so requester 0 has top priority.
REQ-016 LAUNCH: m_start SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT_DONE; m_start SHALL be 0 in every other state.
REQ-017 WAIT_DONE: on m_done=1 the block SHALL capture rdata = m_data_out if latched cmd[9:8]==2'b11, else 8'h00, and go to RESP.
REQ-018 RESP: ack[grant] SHALL be 1 for one cycle with rdata/err valid, last_grant is updated to grant, and the FSM returns to IDLE.
REQ-019 Latency SHALL be 1 cycle from req high (IDLE) to m_start, and ack SHALL come exactly 1 cycle after m_done is sampled.
REQ-020 A requester still asserting req in the cycle after its ack SHALL be treated as a new request and rearbitrated behind other pending requesters.
REQ-021 The block SHALL ignore changes to req/cmd of the granted requester after the IDLE latch cycle, and SHALL ignore m_done outside WAIT_DONE.
REQ-022 m_busy SHALL be observation only: if m_busy=1 in IDLE, the block SHALL not leave IDLE (master not yet free).
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rst=1 the block SHALL hold: state=IDLE, m_start=0, m_data_in=0, ack=0, rdata=0, err=0, last_grant=NUM_REQ-1, timeout counter=0.
REQ-025 Reset mid-transaction SHALL abandon the transaction without issuing an ack; the master is reset separately.

Configuration
REQ-026 With SPI_ARB_TIMEOUT_EN defined, a WAIT_DONE counter SHALL abort after TIMEOUT_CYC cycles without m_done: go to RESP with err=1, rdata=8'hFF; the counter clears on entry to WAIT_DONE.
REQ-027 Without SPI_ARB_TIMEOUT_EN, err SHALL be tied 0, no counter SHALL exist, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-028 Package spi_arb_pkg SHALL hold the state enum, CMD_W=10, RD_W=8 and the RD_OPCODE=2'b11 constant.
REQ-029 Round-robin selection SHALL be sub-module spi_rr_arbiter (req, last_grant -> grant index, valid), purely combinational.

Verification
REQ-030 Single request: req=4'b0001, cmd0=10'h0A5, master m_done 20 cycles after start -> one m_start pulse, m_data_in=10'h0A5, ack=4'b0001 with rdata=8'h00.
REQ-031 Read: req2 with cmd=10'h3C4, m_data_out=8'h5A at m_done -> ack=4'b0100, rdata=8'h5A one cycle after m_done.
REQ-032 Contention: req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0, with no ack lost or duplicated.
REQ-033 Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=64): m_done never asserts -> ack after 64 WAIT_DONE cycles with err=1, rdata=8'hFF; next request serviced normally.
REQ-034 Reset in WAIT_DONE: rst pulsed -> no ack, all outputs zero; after release, req=4'b0010 is granted first by requester 1, since requester 0 is idle.
